// File: rtl/uart_rx_if.sv
// Serial line and received-byte outputs of the UART receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input data, valid, frame_err, busy);
  modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling, single-cycle valid / frame_err pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic     clock,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      // Edge detect keeps a held-low line from re-triggering after a frame error.
      IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor checks pulses.
module tb_uart_rx;
  localparam int unsigned CPB = 16;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned at_cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  int unsigned cyc;
  int unsigned n_checks;
  int unsigned n_pass;
  exp_t        sb[$];

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Caller must be aligned just after a rising edge; slot 0 = start, 9 = stop.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int unsigned nslots);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int unsigned i = 0; i < nslots; i++) begin
      bus.rx = bits[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.at_cyc = cyc + 3 + CPB / 2 + 9 * CPB;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int unsigned t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clock);
      t++;
    end
    #1;
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if (!reset && (bus.valid || bus.frame_err)) begin
      chk("pulse_exclusive", {31'd0, bus.valid && bus.frame_err}, 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, bus.valid, bus.frame_err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, bus.frame_err}, {31'd0, e.is_err});
        chk("pulse_data", {24'd0, bus.data}, {24'd0, e.data});
        chk("pulse_cycle", cyc, e.at_cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.rx   = 1'b1;
    reset    = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("rst_data",  {24'd0, bus.data}, 32'h00);
    chk("rst_valid", {31'd0, bus.valid}, 0);
    chk("rst_ferr",  {31'd0, bus.frame_err}, 0);
    chk("rst_busy",  {31'd0, bus.busy}, 0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;

    // 0x47 with latency check
    expect_ev(1'b0, 8'h47);
    drive_frame(8'h47, 1'b1, 10);
    wait_drain("drain_47");
    chk("idle_after_47", {31'd0, bus.busy}, 0);

    // 4-cycle glitch
    bus.rx = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("glitch_busy", {31'd0, bus.busy}, 1);
    @(posedge clock);
    #1;
    bus.rx = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("glitch_idle", {31'd0, bus.busy}, 0);
    chk("glitch_data", {24'd0, bus.data}, 32'h47);
    wait_drain("drain_glitch");

    // 0x3C with low stop bit
    expect_ev(1'b1, 8'h47);
    drive_frame(8'h3C, 1'b0, 10);
    bus.rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    wait_drain("drain_3c");
    chk("ferr_data_hold", {24'd0, bus.data}, 32'h47);

    // back-to-back 0xA5, 0x5A
    expect_ev(1'b0, 8'hA5);
    drive_frame(8'hA5, 1'b1, 10);
    expect_ev(1'b0, 8'h5A);
    drive_frame(8'h5A, 1'b1, 10);
    wait_drain("drain_b2b");
    chk("b2b_data", {24'd0, bus.data}, 32'h5A);

    // reset in the middle of 0xFF, then 0x81
    drive_frame(8'hFF, 1'b1, 5);
    chk("mid_busy", {31'd0, bus.busy}, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mrst_data",  {24'd0, bus.data}, 32'h00);
    chk("mrst_valid", {31'd0, bus.valid}, 0);
    chk("mrst_ferr",  {31'd0, bus.frame_err}, 0);
    chk("mrst_busy",  {31'd0, bus.busy}, 0);
    repeat (120) @(posedge clock);
    #1;
    chk("mrst_still_idle", {31'd0, bus.busy}, 0);
    wait_drain("drain_mrst");
    expect_ev(1'b0, 8'h81);
    drive_frame(8'h81, 1'b1, 10);
    wait_drain("drain_81");

    // break: line held low 400 cycles
    expect_ev(1'b1, 8'h81);
    bus.rx = 1'b0;
    repeat (400) @(posedge clock);
    #1;
    chk("break_busy_low", {31'd0, bus.busy}, 0);
    bus.rx = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    wait_drain("drain_break");
    chk("break_busy", {31'd0, bus.busy}, 0);
    chk("break_data", {24'd0, bus.data}, 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
